// File: rtl/angle_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : angle_seq_pkg
//  Desc     : Shared state encoding and constants for the angle step sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package angle_seq_pkg;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t c_IDLE       = 3'd0;
   localparam seq_state_t c_INIT       = 3'd1;
   localparam seq_state_t c_RUN_HI     = 3'd2;
   localparam seq_state_t c_RUN_LO     = 3'd3;
   localparam seq_state_t c_ABORT_FALL = 3'd4;
   localparam seq_state_t c_DONE       = 3'd5;

   localparam int c_MAX_STEPS    = 9999;
   localparam int c_INIT_CYC_DEF = 2;

endpackage
`default_nettype wire

// File: rtl/angle_step_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : angle_step_sequencer_if
//  Desc     : Command/status bundle between command logic and the sequencer.
//             half_div exists only when ANGLE_SEQ_RATE_PORT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface angle_step_sequencer_if #(
   parameter int CNT_W = 14
`ifdef ANGLE_SEQ_RATE_PORT_EN
   , parameter int DIV_W = 17
`endif
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_steps;
   logic             cmd_init;
   logic             abort;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] steps_left;
`ifdef ANGLE_SEQ_RATE_PORT_EN
   logic [DIV_W-1:0] half_div;
`endif

   modport master (
`ifdef ANGLE_SEQ_RATE_PORT_EN
      output half_div,
`endif
      output cmd_valid, cmd_steps, cmd_init, abort,
      input  cmd_ready, busy, done, aborted, steps_left
   );

   modport slave (
`ifdef ANGLE_SEQ_RATE_PORT_EN
      input  half_div,
`endif
      input  cmd_valid, cmd_steps, cmd_init, abort,
      output cmd_ready, busy, done, aborted, steps_left
   );
endinterface
`default_nettype wire

// File: rtl/angle_step_sequencer_step_rate_divider.sv
`default_nettype none
// ============================================================================
//  Module   : step_rate_divider
//  Desc     : Half-period down-counter; tick marks the last cycle of a period.
//  Revision : 1.0 - initial release
// ============================================================================
module step_rate_divider #(
   parameter int DIV_W = 17
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             load,
   input  wire logic [DIV_W-1:0] load_val,
   output logic                  tick
);
   logic [DIV_W-1:0] r_cnt;

   // Holds at zero after expiry; the sequencer always reloads on state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (load)
         r_cnt <= load_val - DIV_W'(1);
      else if (r_cnt != '0)
         r_cnt <= r_cnt - DIV_W'(1);
   end

   assign tick = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/angle_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : angle_step_sequencer
//  Desc     : Drives sys_init_ctrl/rot_clk/rot_en so the BCD angle counter
//             advances a commanded number of steps. Optional macro:
//             ANGLE_SEQ_RATE_PORT_EN (run-time half-period input).
//  Revision : 1.0 - initial release
// ============================================================================
module angle_step_sequencer
   import angle_seq_pkg::*;
#(
   parameter int STEP_DIV = 100000,
   parameter int CNT_W    = 14,
   parameter int DIV_W    = 17,
   parameter int INIT_CYC = c_INIT_CYC_DEF
) (
   input  wire logic             fpga_clk,
   input  wire logic             sys_rst_n,
   angle_step_sequencer_if.slave cmd_if,
   output logic                  sys_init_ctrl,
   output logic                  rot_clk,
   output logic                  rot_en
);
   localparam int               c_INIT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
   localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(INIT_CYC - 1);
   localparam logic [DIV_W-1:0] c_HALF_DEF  = DIV_W'(STEP_DIV / 2);

   seq_state_t          r_state;
   seq_state_t          w_state_nxt;
   logic [CNT_W-1:0]    r_steps_left;
   logic [c_INIT_W-1:0] r_init_cnt;
   logic [DIV_W-1:0]    w_half;
   logic                r_cmd_ready, r_busy, r_done, r_aborted;
   logic                w_accept, w_tick, w_load, w_abort_exit;

   assign w_accept = cmd_if.cmd_valid && r_cmd_ready;

`ifdef ANGLE_SEQ_RATE_PORT_EN
   logic [DIV_W-1:0] r_half;
   logic [DIV_W-1:0] w_half_in;

   assign w_half_in = (cmd_if.half_div == '0) ? DIV_W'(1) : cmd_if.half_div;
   // The first RUN_HI load happens on the accept edge, before r_half updates.
   assign w_half    = w_accept ? w_half_in : r_half;

   always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         r_half <= c_HALF_DEF;
      else if (w_accept)
         r_half <= w_half_in;
   end
`else
   assign w_half = c_HALF_DEF;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_abort_exit = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               if (cmd_if.cmd_init)
                  w_state_nxt = c_INIT;
               else if (cmd_if.cmd_steps != '0)
                  w_state_nxt = c_RUN_HI;
               else
                  w_state_nxt = c_DONE;
            end
         end
         c_INIT: begin
            if (cmd_if.abort) begin
               w_state_nxt  = c_DONE;
               w_abort_exit = 1'b1;
            end else if (r_init_cnt == '0) begin
               w_state_nxt = (r_steps_left != '0) ? c_RUN_HI : c_DONE;
            end
         end
         c_RUN_HI: begin
            if (cmd_if.abort)
               w_state_nxt = c_ABORT_FALL;
            else if (w_tick)
               w_state_nxt = c_RUN_LO;
         end
         c_RUN_LO: begin
            if (cmd_if.abort) begin
               w_state_nxt  = c_DONE;
               w_abort_exit = 1'b1;
            end else if (w_tick) begin
               w_state_nxt = (r_steps_left != '0) ? c_RUN_HI : c_DONE;
            end
         end
         c_ABORT_FALL: begin
            w_state_nxt  = c_DONE;
            w_abort_exit = 1'b1;
         end
         c_DONE:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   assign w_load = (w_state_nxt != r_state) &&
                   ((w_state_nxt == c_RUN_HI) || (w_state_nxt == c_RUN_LO));

   step_rate_divider #(
      .DIV_W (DIV_W)
   ) u_step_rate_divider (
      .clk      (fpga_clk),
      .rst_n    (sys_rst_n),
      .load     (w_load),
      .load_val (w_half),
      .tick     (w_tick)
   );

   // Outputs are registered from the next state so they align with it.
   always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state       <= c_IDLE;
         r_steps_left  <= '0;
         r_init_cnt    <= '0;
         r_cmd_ready   <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         sys_init_ctrl <= 1'b0;
         rot_clk       <= 1'b0;
         rot_en        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept)
            r_steps_left <= cmd_if.cmd_steps;
         else if ((r_state == c_RUN_HI) && (w_state_nxt == c_RUN_LO))
            r_steps_left <= r_steps_left - CNT_W'(1);

         if ((w_state_nxt == c_INIT) && (r_state != c_INIT))
            r_init_cnt <= c_INIT_LAST;
         else if (r_init_cnt != '0)
            r_init_cnt <= r_init_cnt - c_INIT_W'(1);

         r_cmd_ready   <= (w_state_nxt == c_IDLE);
         r_busy        <= (w_state_nxt != c_IDLE) && (w_state_nxt != c_DONE);
         r_done        <= (w_state_nxt == c_DONE);
         r_aborted     <= (w_state_nxt == c_DONE) && w_abort_exit;
         sys_init_ctrl <= (w_state_nxt == c_INIT);
         rot_clk       <= (w_state_nxt == c_RUN_HI) || (w_state_nxt == c_ABORT_FALL);
         rot_en        <= (w_state_nxt == c_RUN_HI) || (w_state_nxt == c_RUN_LO);
      end
   end

   assign cmd_if.cmd_ready  = r_cmd_ready;
   assign cmd_if.busy       = r_busy;
   assign cmd_if.done       = r_done;
   assign cmd_if.aborted    = r_aborted;
   assign cmd_if.steps_left = r_steps_left;

endmodule
`default_nettype wire

// File: tb/tb_angle_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_angle_step_sequencer
//  Desc     : Directed bench with a BCD angle-counter model and a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_angle_step_sequencer;
   localparam int STEP_DIV = 4;
   localparam int CNT_W    = 14;
   localparam int DIV_W    = 8;

   logic fpga_clk  = 1'b0;
   logic sys_rst_n = 1'b0;
   logic sys_init_ctrl, rot_clk, rot_en;

   angle_step_sequencer_if #(
      .CNT_W (CNT_W)
`ifdef ANGLE_SEQ_RATE_PORT_EN
      , .DIV_W (DIV_W)
`endif
   ) cmd_if ();

   angle_step_sequencer #(
      .STEP_DIV (STEP_DIV),
      .CNT_W    (CNT_W),
      .DIV_W    (DIV_W),
      .INIT_CYC (2)
   ) dut (
      .fpga_clk      (fpga_clk),
      .sys_rst_n     (sys_rst_n),
      .cmd_if        (cmd_if),
      .sys_init_ctrl (sys_init_ctrl),
      .rot_clk       (rot_clk),
      .rot_en        (rot_en)
   );

   always #5 fpga_clk = ~fpga_clk;

   // ---- BCD angle counter model plus edge monitors ----
   logic [15:0] bcd     = 16'h0000;
   logic        pre_en  = 1'b0;
   logic [15:0] pre_val = 16'h0000;
   logic        prev_rclk = 1'b0, prev_en = 1'b0, have_last = 1'b0;
   int cyc = 0, falls_en = 0, falls_dead = 0, init_hi = 0;
   int spacing_err = 0, last_fall = 0, en_fall_cyc = 0, abort_gap = 0;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int d = 0; d < 4; d++) begin
         if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
         else begin
            r[4*d +: 4] = r[4*d +: 4] + 4'd1;
            break;
         end
      end
      return r;
   endfunction

   function automatic int from_bcd(input logic [15:0] v);
      return 1000*int'(v[15:12]) + 100*int'(v[11:8]) + 10*int'(v[7:4]) + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n/1000%10), 4'(n/100%10), 4'(n/10%10), 4'(n%10)};
   endfunction

   always @(posedge fpga_clk) begin
      cyc       <= cyc + 1;
      prev_rclk <= rot_clk;
      prev_en   <= rot_en;
      if (pre_en)                                bcd <= pre_val;
      else if (sys_init_ctrl)                    bcd <= 16'h0000;
      else if (prev_rclk && !rot_clk && rot_en)  bcd <= bcd_inc(bcd);
      if (sys_init_ctrl) init_hi <= init_hi + 1;
      if (prev_en && !rot_en && rot_clk) en_fall_cyc <= cyc;
      if (prev_rclk && !rot_clk) begin
         if (rot_en) begin
            falls_en <= falls_en + 1;
            if (have_last && (cyc - last_fall != STEP_DIV)) spacing_err <= spacing_err + 1;
            last_fall <= cyc;
            have_last <= 1'b1;
         end else begin
            falls_dead <= falls_dead + 1;
            abort_gap  <= cyc - en_fall_cyc;
         end
      end else if (!cmd_if.busy) begin
         have_last <= 1'b0;
      end
   end

   // ---- scoreboard ----
   typedef struct {
      bit          aborted;
      int          steps_left;
      logic [15:0] bcd;
      int          falls;
   } exp_t;
   exp_t sb_q[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input bit ab, input int left, input int n, input bit clr);
      exp_t e;
      e.aborted    = ab;
      e.steps_left = left;
      e.bcd        = to_bcd(((clr ? 0 : from_bcd(bcd)) + n) % 10000);
      e.falls      = falls_en + n;
      sb_q.push_back(e);
   endtask

   task automatic send(input int steps, input bit init, input bit hold);
      int n = 0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_steps = CNT_W'(steps);
      cmd_if.cmd_init  = init;
      while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
         @(negedge fpga_clk);
         n++;
      end
      @(negedge fpga_clk);
      if (!hold) cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      exp_t e;
      int   n = 0;
      while (cmd_if.done !== 1'b1 && n < 400) begin
         @(negedge fpga_clk);
         n++;
      end
      chk({tag, "_done"}, 32'(cmd_if.done), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, "_aborted"},    32'(cmd_if.aborted),    32'(e.aborted));
         chk({tag, "_steps_left"}, 32'(cmd_if.steps_left), 32'(e.steps_left));
         chk({tag, "_busy"},       32'(cmd_if.busy),       32'd0);
         chk({tag, "_bcd"},        32'(bcd),               32'(e.bcd));
         chk({tag, "_falls"},      32'(falls_en),          32'(e.falls));
      end
      @(negedge fpga_clk);
      chk({tag, "_done_pulse"}, 32'(cmd_if.done),      32'd0);
      chk({tag, "_ready_back"}, 32'(cmd_if.cmd_ready), 32'd1);
   endtask

   initial begin
      int i0, d0, n;
      logic [15:0] snap;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_steps = '0;
      cmd_if.cmd_init  = 1'b0;
      cmd_if.abort     = 1'b0;
`ifdef ANGLE_SEQ_RATE_PORT_EN
      cmd_if.half_div  = DIV_W'(STEP_DIV / 2);
`endif
      repeat (3) @(negedge fpga_clk);

      // reset state
      chk("rst_ready",   32'(cmd_if.cmd_ready), 32'd1);
      chk("rst_busy",    32'(cmd_if.busy),      32'd0);
      chk("rst_rot_clk", 32'(rot_clk),          32'd0);
      chk("rst_rot_en",  32'(rot_en),           32'd0);
      chk("rst_init",    32'(sys_init_ctrl),    32'd0);
      chk("rst_left",    32'(cmd_if.steps_left), 32'd0);
      sys_rst_n = 1'b1;
      @(negedge fpga_clk);

      // 1: three plain steps
      sb_push(1'b0, 0, 3, 1'b0);
      send(3, 1'b0, 1'b0);
      chk("t1_left_latched", 32'(cmd_if.steps_left), 32'd3);
      chk("t1_rot_en",       32'(rot_en),            32'd1);
      wait_done("t1");

      // 2: init only, counter preloaded at 0042
      pre_val = 16'h0042; pre_en = 1'b1;
      @(negedge fpga_clk);
      pre_en = 1'b0;
      i0 = init_hi;
      sb_push(1'b0, 0, 0, 1'b1);
      send(0, 1'b1, 1'b0);
      wait_done("t2");
      chk("t2_init_cycles", 32'(init_hi - i0), 32'd2);

      // 3: wrap through 9999
      pre_val = 16'h9998; pre_en = 1'b1;
      @(negedge fpga_clk);
      pre_en = 1'b0;
      sb_push(1'b0, 0, 3, 1'b0);
      send(3, 1'b0, 1'b0);
      wait_done("t3");

      // 4: abort during the second high phase
      d0 = falls_dead;
      sb_push(1'b1, 4, 1, 1'b0);
      send(5, 1'b0, 1'b0);
      n = 0;
      while (rot_clk !== 1'b0 && n < 50) begin @(negedge fpga_clk); n++; end
      while (rot_clk !== 1'b1 && n < 50) begin @(negedge fpga_clk); n++; end
      chk("t4_second_hi", 32'(rot_clk), 32'd1);
      cmd_if.abort = 1'b1;
      @(negedge fpga_clk);
      chk("t4_en_drop", 32'(rot_en),  32'd0);
      chk("t4_clk_hold", 32'(rot_clk), 32'd1);
      @(negedge fpga_clk);
      chk("t4_clk_drop", 32'(rot_clk), 32'd0);
      wait_done("t4");
      cmd_if.abort = 1'b0;
      chk("t4_dead_fall", 32'(falls_dead - d0), 32'd1);
      chk("t4_en_gap",    32'(abort_gap),       32'd1);

      // 5: command held while busy is ignored until IDLE
      sb_push(1'b0, 0, 2, 1'b0);
      send(2, 1'b0, 1'b1);
      cmd_if.cmd_steps = CNT_W'(7);
      wait_done("t5a");
      sb_push(1'b0, 0, 7, 1'b0);
      @(negedge fpga_clk);
      chk("t5_accept_busy",  32'(cmd_if.busy),       32'd1);
      chk("t5_accept_ready", 32'(cmd_if.cmd_ready),  32'd0);
      chk("t5_accept_left",  32'(cmd_if.steps_left), 32'd7);
      cmd_if.cmd_valid = 1'b0;
      wait_done("t5b");

      // 6: reset pulse during a high phase
      send(3, 1'b0, 1'b0);
      chk("t6_in_hi", 32'(rot_clk), 32'd1);
      snap = bcd;
      sys_rst_n = 1'b0;
      #1;
      chk("t6_ready",   32'(cmd_if.cmd_ready),  32'd1);
      chk("t6_busy",    32'(cmd_if.busy),       32'd0);
      chk("t6_rot_clk", 32'(rot_clk),           32'd0);
      chk("t6_rot_en",  32'(rot_en),            32'd0);
      chk("t6_done",    32'(cmd_if.done),       32'd0);
      chk("t6_left",    32'(cmd_if.steps_left), 32'd0);
      repeat (3) @(negedge fpga_clk);
      chk("t6_bcd_hold", 32'(bcd), 32'(snap));
      sys_rst_n = 1'b1;
      repeat (3) @(negedge fpga_clk);
      chk("t6_idle_busy", 32'(cmd_if.busy), 32'd0);

      chk("step_spacing_errors", 32'(spacing_err), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
